multicycle_data_memory: RTL

//  Parametrised word-organised data memory for the multicycle RISC-V datapath.

---
 rtl/multicycle_data_memory.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_data_memory.sv
// Word-organised data memory for the multicycle RV32 datapath: sized little-endian
// loads/stores with a configurable wait-state count and a one-cycle done pulse.
module multicycle_data_memory #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [2:0]            funct3,
    input  logic                  memRead,
    input  logic                  memWrite,
    output logic [DATA_WIDTH-1:0] memData,
    output logic                  memReady,
    output logic                  memError
);
    localparam int              AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]      WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_commit;
    logic [3:0]            r_cnt;
    logic [31:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_f3;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ready;
    logic                  r_error;

    logic [AW-1:0]         w_index;
    logic [1:0]            w_lane;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_bad;
    logic [DATA_WIDTH-1:0] w_load_val;
    logic [DATA_WIDTH-1:0] w_store_word;

    // Misaligned half/word, unknown funct3, and unsigned-store encodings are rejected.
    function automatic logic access_error(input logic [2:0] f3, input logic wr,
                                          input logic [1:0] lane);
        logic err;
        case (f3)
            3'b000:  err = 1'b0;
            3'b001:  err = lane[0];
            3'b010:  err = (lane != 2'b00);
            3'b100:  err = wr;
            3'b101:  err = wr | lane[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [31:0] word,
                                                input logic [31:0] wd, input logic [1:0] lane);
        logic [31:0] res;
        res = word;
        case (f3)
            3'b000:  res[{lane, 3'b000} +: 8] = wd[7:0];
            3'b001:  res[{lane[1], 4'b0000} +: 16] = wd[15:0];
            3'b010:  res = wd;
            default: res = word;
        endcase
        return res;
    endfunction

    assign w_index      = AW'(r_addr >> 2);
    assign w_lane       = r_addr[1:0];
    assign w_word       = r_mem[w_index];
    assign w_bad        = access_error(r_f3, r_wr, w_lane);
    assign w_load_val   = load_extend(r_f3, w_word, w_lane);
    assign w_store_word = store_merge(r_f3, w_word, r_wdata, w_lane);

    // Next-state logic; the access commits on the BUSY edge where the counter is exhausted.
    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (memRead | memWrite) w_next = ST_BUSY;
                else                    w_next = ST_IDLE;
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_next   = ST_DONE;
                    w_commit = 1'b1;
                end else begin
                    w_next = ST_BUSY;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State, request capture, wait counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= {DATA_WIDTH{1'b0}};
            r_f3    <= 3'd0;
            r_wr    <= 1'b0;
            r_data  <= {DATA_WIDTH{1'b0}};
            r_ready <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && (memRead | memWrite)) begin
                r_addr  <= address;
                r_wdata <= writeData;
                r_f3    <= funct3;
                r_wr    <= memWrite;
                r_cnt   <= WAIT_CNT;
            end else if (r_state == ST_BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_ready <= w_commit;
            r_error <= w_commit & w_bad;
            if (w_commit && !w_bad && !r_wr) begin
                r_data <= w_load_val;
            end
        end
    end

    // Storage array; cleared by reset so an aborted store can never leave residue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (w_commit && !w_bad && r_wr) begin
            r_mem[w_index] <= w_store_word;
        end
    end

    assign memData  = r_data;
    assign memReady = r_ready;
    assign memError = r_error;
endmodule
